// File: rtl/alu_instr_encoder.sv
// Issue-side front end for the combinational ALU: queues operation requests, encodes them as
// MIPS instruction words, and returns the captured ALU result on a valid/ready response port.
module alu_instr_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SEQ_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic             req_src_a,
    input  logic             req_src_b,
    input  logic [4:0]       req_shamt,
    input  logic [15:0]      req_imm,
    output logic [31:0]      alu_instr,
    input  logic [31:0]      alu_result,
    input  logic [2:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err,
    output logic [SEQ_W-1:0] rsp_seq,
    output logic             busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);
    localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;
    state_t state_q, state_d;

    logic [5:0]  code;
    logic        is_r, illegal, is_shift;
    logic [31:0] enc_instr;

    always_comb begin
        code    = 6'h00;
        illegal = 1'b0;
        case (req_op)
            5'd0:  code = 6'h20;
            5'd1:  code = 6'h21;
            5'd2:  code = 6'h22;
            5'd3:  code = 6'h23;
            5'd4:  code = 6'h24;
            5'd5:  code = 6'h25;
            5'd6:  code = 6'h27;
            5'd7:  code = 6'h26;
            5'd8:  code = 6'h2A;
            5'd9:  code = 6'h2B;
            5'd10: code = 6'h00;
            5'd11: code = 6'h04;
            5'd12: code = 6'h02;
            5'd13: code = 6'h06;
            5'd14: code = 6'h03;
            5'd15: code = 6'h07;
            5'd16: code = 6'h08;
            5'd17: code = 6'h09;
            5'd18: code = 6'h0C;
            5'd19: code = 6'h0D;
            5'd20: code = 6'h0E;
            5'd21: code = 6'h04;
            5'd22: code = 6'h05;
            5'd23: code = 6'h0A;
            5'd24: code = 6'h0B;
            5'd25: code = 6'h23;
            5'd26: code = 6'h2B;
            default: illegal = 1'b1;
        endcase
        is_r     = (req_op < 5'd16);
        is_shift = (req_op >= 5'd10) && (req_op <= 5'd15);
        if (illegal) begin
            enc_instr = 32'h0;
        end else if (is_r) begin
            enc_instr = {6'h00, 4'h0, req_src_a, 4'h0, req_src_b, 5'h00,
                         is_shift ? req_shamt : 5'h00, code};
        end else begin
            enc_instr = {code, 4'h0, req_src_a, 4'h0, req_src_b, req_imm};
        end
    end

    // Entries are stored pre-encoded along with their legality and sequence tag.
    logic [31:0]      mem_instr [DEPTH];
    logic             mem_err   [DEPTH];
    logic [SEQ_W-1:0] mem_seq   [DEPTH];
    logic [PW:0]      wr_ptr_q, rd_ptr_q;
    logic [SEQ_W-1:0] seq_q;
    logic             empty, full, push, pop;
    logic [31:0]      head_instr;
    logic             head_err;
    logic [SEQ_W-1:0] head_seq;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign req_ready  = !full;
    assign push       = req_valid && !full;
    assign head_instr = mem_instr[rd_ptr_q[PW-1:0]];
    assign head_err   = mem_err[rd_ptr_q[PW-1:0]];
    assign head_seq   = mem_seq[rd_ptr_q[PW-1:0]];
    assign rsp_valid  = (state_q == StResp);
    assign busy       = !empty || (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = head_err ? StResp : StExec;
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = head_err ? StResp : StExec;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr_q[PW-1:0]] <= enc_instr;
            mem_err[wr_ptr_q[PW-1:0]]   <= illegal;
            mem_seq[wr_ptr_q[PW-1:0]]   <= seq_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            seq_q      <= '0;
            alu_instr  <= 32'h0;
            rsp_result <= 32'h0;
            rsp_flags  <= 3'h0;
            rsp_err    <= 1'b0;
            rsp_seq    <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
                seq_q    <= seq_q + SEQ_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                rsp_seq  <= head_seq;
                // Illegal ops leave the ALU instruction untouched and respond immediately.
                if (head_err) begin
                    rsp_err    <= 1'b1;
                    rsp_result <= 32'h0;
                    rsp_flags  <= 3'h0;
                end else begin
                    alu_instr <= head_instr;
                end
            end
            if (state_q == StExec) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
                rsp_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Self-checking bench for alu_instr_encoder: directed steps plus randomized requests checked
// against a table-driven encoding model and a behavioural ALU with regA=5, regB=7.
module tb_alu_instr_encoder;

    localparam logic [31:0] REG_A = 32'd5;
    localparam logic [31:0] REG_B = 32'd7;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_src_a, req_src_b;
    logic [4:0]  req_op, req_shamt;
    logic [15:0] req_imm;
    logic [31:0] alu_instr, alu_result, rsp_result;
    logic [2:0]  alu_flags, rsp_flags;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0]  rsp_seq;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  seq;
        bit          err;
        logic [31:0] instr;
    } exp_t;
    exp_t        exp_q[$];
    logic [7:0]  model_seq;
    logic [31:0] last_instr;

    logic [5:0] code_tab [27] = '{
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2A, 6'h2B,
        6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07,
        6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05, 6'h0A, 6'h0B, 6'h23, 6'h2B};

    always #5 clk = ~clk;

    alu_instr_encoder #(.DEPTH(4), .SEQ_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src_a(req_src_a), .req_src_b(req_src_b),
        .req_shamt(req_shamt), .req_imm(req_imm), .alu_instr(alu_instr),
        .alu_result(alu_result), .alu_flags(alu_flags), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_err(rsp_err), .rsp_seq(rsp_seq), .busy(busy)
    );

    function automatic logic [34:0] alu_fn(input logic [31:0] ins);
        logic [31:0] a, b, sx, zx, r;
        logic [4:0]  sh, va;
        logic        ov;
        a  = ins[21] ? REG_B : REG_A;
        b  = ins[16] ? REG_B : REG_A;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0, ins[15:0]};
        sh = ins[10:6];
        va = a[4:0];
        ov = 1'b0;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h20, 6'h21: r = a + b;
                6'h22, 6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h27: r = ~(a | b);
                6'h26: r = a ^ b;
                6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: r = (a < b) ? 32'd1 : 32'd0;
                6'h00: r = b << sh;
                6'h04: r = b << va;
                6'h02: r = b >> sh;
                6'h06: r = b >> va;
                6'h03: r = 32'($signed(b) >>> sh);
                6'h07: r = 32'($signed(b) >>> va);
                default: r = ins;
            endcase
            if (ins[5:0] == 6'h20) ov = (a[31] == b[31]) && (r[31] != a[31]);
            if (ins[5:0] == 6'h22) ov = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            case (ins[31:26])
                6'h08, 6'h09, 6'h23, 6'h2B: r = a + sx;
                6'h0C: r = a & zx;
                6'h0D: r = a | zx;
                6'h0E: r = a ^ zx;
                6'h0A: r = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
                6'h0B: r = (a < sx) ? 32'd1 : 32'd0;
                6'h04, 6'h05: r = a - b;
                default: r = ins;
            endcase
            if (ins[31:26] == 6'h08) ov = (a[31] == sx[31]) && (r[31] != a[31]);
        end
        return {ov, r[31], (r == 32'h0), r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_fn(alu_instr);

    function automatic logic [31:0] enc(input logic [4:0] op, input logic sa, input logic sb,
                                        input logic [4:0] sh, input logic [15:0] imm);
        logic [5:0] c;
        c = code_tab[op];
        if (op < 5'd16)
            return {6'h00, 4'h0, sa, 4'h0, sb, 5'h00, (op >= 5'd10) ? sh : 5'h00, c};
        return {c, 4'h0, sa, 4'h0, sb, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_seq  = 8'h0;
        last_instr = 32'h0;
    endtask

    task automatic send(input logic [4:0] op, input logic sa, input logic sb,
                        input logic [4:0] sh, input logic [15:0] imm);
        exp_t e;
        bit   done = 0;
        req_op = op; req_src_a = sa; req_src_b = sb; req_shamt = sh; req_imm = imm;
        req_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            if (req_ready) done = 1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!done) begin
            timeout("req_accept");
        end else begin
            e.seq   = model_seq;
            e.err   = (op > 5'd26);
            e.instr = e.err ? 32'h0 : enc(op, sa, sb, sh, imm);
            exp_q.push_back(e);
            model_seq = model_seq + 8'd1;
        end
    endtask

    task automatic wait_valid(output bit seen);
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            if (rsp_valid) seen = 1;
            else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic get_rsp();
        exp_t        e;
        bit          seen;
        logic [34:0] ar;
        rsp_ready = 1'b1;
        wait_valid(seen);
        if (!seen) begin
            timeout("rsp_valid");
        end else if (exp_q.size() == 0) begin
            timeout("rsp_unexpected");
        end else begin
            e = exp_q.pop_front();
            if (!e.err) last_instr = e.instr;
            ar = e.err ? 35'h0 : alu_fn(e.instr);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("alu_instr", alu_instr, last_instr);
            chk("rsp_result", rsp_result, ar[31:0]);
            chk("rsp_flags", 32'(rsp_flags), 32'(ar[34:32]));
            chk("rsp_seq", 32'(rsp_seq), 32'(e.seq));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        logic [31:0] snap_res, snap_instr;
        logic [7:0]  snap_seq;
        logic [4:0]  op, sh;
        logic [15:0] imm;
        int          k;

        req_op = 5'h0; req_src_a = 1'b0; req_src_b = 1'b0; req_shamt = 5'h0; req_imm = 16'h0;
        do_reset();
        chk("rst_alu_instr", alu_instr, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rsp_seq", 32'(rsp_seq), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);

        // addi latency: accepted in t, instr at t+2, response at t+3
        send(5'd16, 1'b1, 1'b0, 5'd0, 16'hFFFF);
        @(posedge clk); #1;
        chk("addi_instr_t2", alu_instr, 32'h2020FFFF);
        chk("addi_novalid_t2", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        chk("addi_valid_t3", 32'(rsp_valid), 32'h1);
        chk("addi_seq", 32'(rsp_seq), 32'h0);
        get_rsp();

        send(5'd2, 1'b0, 1'b1, 5'd0, 16'h0);
        wait_valid(seen);
        chk("sub_instr", alu_instr, 32'h00010022);
        chk("sub_result", rsp_result, 32'hFFFFFFFE);
        chk("sub_flags", 32'(rsp_flags), 32'h2);
        get_rsp();

        send(5'd10, 1'b0, 1'b1, 5'd4, 16'h0);
        wait_valid(seen);
        chk("sll_instr", alu_instr, 32'h00010100);
        get_rsp();
        send(5'd15, 1'b0, 1'b1, 5'd0, 16'h0);
        wait_valid(seen);
        chk("srav_instr", alu_instr, 32'h00010007);
        get_rsp();

        send(5'd31, 1'b1, 1'b1, 5'd3, 16'h1234);
        wait_valid(seen);
        chk("ill_err", 32'(rsp_err), 32'h1);
        chk("ill_result", rsp_result, 32'h0);
        chk("ill_instr_hold", alu_instr, 32'h00010007);
        get_rsp();
        send(5'd5, 1'b1, 1'b0, 5'd0, 16'h0);
        get_rsp();

        // Stall: five requests fill FSM + FIFO, responses must hold steady
        do_reset();
        for (int i = 0; i < 5; i++) send(5'(i), 1'(i), 1'(i + 1), 5'd0, 16'h0);
        chk("full_req_ready", 32'(req_ready), 32'h0);
        chk("full_busy", 32'(busy), 32'h1);
        @(posedge clk); #1;
        chk("stall_valid", 32'(rsp_valid), 32'h1);
        snap_res = rsp_result; snap_instr = alu_instr; snap_seq = rsp_seq;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_result", rsp_result, snap_res);
        chk("stall_instr", alu_instr, snap_instr);
        chk("stall_seq", 32'(rsp_seq), 32'(snap_seq));
        for (int i = 0; i < 5; i++) get_rsp();

        // Reset while a response is pending with two entries queued
        do_reset();
        for (int i = 0; i < 3; i++) send(5'd1, 1'b0, 1'b1, 5'd0, 16'h0);
        wait_valid(seen);
        chk("mid_valid_before", 32'(rsp_valid), 32'h1);
        do_reset();
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_req_ready", 32'(req_ready), 32'h1);
        send(5'd7, 1'b1, 1'b0, 5'd0, 16'h0);
        get_rsp();
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_extra_rsp", 32'(rsp_valid), 32'h0);

        // Randomized bursts of requests, drained in order
        for (int b = 0; b < 25; b++) begin
            k = $urandom_range(1, 5);
            for (int i = 0; i < k; i++) begin
                op  = 5'($urandom_range(0, 31));
                sh  = 5'($urandom_range(0, 31));
                imm = 16'($urandom_range(0, 65535));
                send(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sh, imm);
            end
            for (int i = 0; i < k; i++) get_rsp();
        end
        chk("final_idle_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
